// File: rtl/breakout_pkg.sv
// ------------------------------------------------------------------
// breakout_pkg : shared constants and types for the breakout core. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package breakout_pkg;

  localparam int SPI_CMD_WR_BIT = 7;
  localparam int SPI_ADDR_W     = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_pin_sync.sv
// ------------------------------------------------------------------
// spi_pin_sync : multi-flop synchronizer plus history flop with edge detect. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic nRst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

`default_nettype wire

// File: rtl/spi_reg_slave.sv
// ------------------------------------------------------------------
// spi_reg_slave : SPI mode-0 slave bridging the pins to a register bus. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module spi_reg_slave
  import breakout_pkg::*;
#(
  parameter int ADDR_W      = SPI_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              en,
  input  logic              sck_pin,
  input  logic              ss_pin,
  input  logic              mosi_pin,
  output logic              miso,
  output logic              miso_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  localparam int FLUSH_N = SYNC_STAGES + 1;
  localparam int FLUSH_W = $clog2(FLUSH_N + 1);

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .nRst(nRst), .pin(sck_pin),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .nRst(nRst), .pin(ss_pin),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .nRst(nRst), .pin(mosi_pin),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sck_level, ss_rise, mosi_rise, mosi_fall};

  spi_state_t          state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;
  logic                reg_wr_q, reg_wr_d;
  logic                reg_rd_q, reg_rd_d;
  logic                cap_q, cap_d;
  logic                miso_q, miso_d;
  logic                armed_q, armed_d;
  logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic                flush_done;
  logic [7:0]          rx_byte;

  // The SS preset is flushed out after reset before a fall may start a transaction,
  // so a select already held low across reset release is never mistaken for a new frame.
  assign flush_done = (flush_cnt_q == FLUSH_W'(FLUSH_N));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    cap_d       = reg_rd_q;
    miso_d      = miso_q;
    armed_d     = armed_q | (ss_level & flush_done);
    flush_cnt_d = flush_done ? flush_cnt_q : flush_cnt_q + FLUSH_W'(1);
    rx_byte     = {rx_q[6:0], mosi_level};

    if (reg_wr_q) begin
      reg_addr_d = reg_addr_q + ADDR_W'(1);
    end

    if (state_q == IDLE) begin
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      if (en && armed_q && ss_fall) begin
        state_d = CMD;
      end
    end else if (!en || ss_level) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else begin
      if (sck_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              reg_addr_d = rx_byte[ADDR_W-1:0];
              if (rx_byte[SPI_CMD_WR_BIT]) begin
                state_d = WR_DATA;
              end else begin
                state_d  = RD_DATA;
                reg_rd_d = 1'b1;
              end
            end
            WR_DATA: begin
              reg_wdata_d = rx_byte;
              reg_wr_d    = 1'b1;
            end
            RD_DATA: begin
              reg_addr_d = reg_addr_q + ADDR_W'(1);
              reg_rd_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (state_q == RD_DATA) begin
        if (sck_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end else begin
        miso_d = 1'b0;
      end
    end

    if (cap_q) begin
      tx_d = reg_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'd0;
      tx_q        <= 8'd0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      cap_q       <= 1'b0;
      miso_q      <= 1'b0;
      armed_q     <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      cap_q       <= cap_d;
      miso_q      <= miso_d;
      armed_q     <= armed_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign miso_en   = busy;
  assign miso      = miso_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
// ------------------------------------------------------------------
// tb_spi_reg_slave : scoreboard bench for spi_reg_slave with a bus-level SPI master. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_slave;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       en = 1'b1;
  logic       sck_pin = 1'b0;
  logic       ss_pin = 1'b1;
  logic       mosi_pin = 1'b0;
  logic       miso, miso_en, reg_wr, reg_rd, busy;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  logic [7:0] rmem [0:127];
  logic [7:0] txd [0:3];
  ev_t        sb [$];
  ev_t        mon_ev;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign reg_rdata = rmem[reg_addr];

  spi_reg_slave #(.ADDR_W(7), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .nRst(nRst), .en(en),
    .sck_pin(sck_pin), .ss_pin(ss_pin), .mosi_pin(mosi_pin),
    .miso(miso), .miso_en(miso_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the next expected bus event.
  always @(negedge clk) begin
    if (reg_wr || reg_rd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: got wr=%b rd=%b addr=%h expected no strobe at %0t",
                 reg_wr, reg_rd, reg_addr, $time);
      end else begin
        mon_ev = sb.pop_front();
        check("strobe_kind_addr", {reg_wr, reg_rd, reg_addr}, {mon_ev.wr, ~mon_ev.wr, mon_ev.addr});
        if (mon_ev.wr) check("strobe_wdata", reg_wdata, mon_ev.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic spi_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ss_low(input bit glitch);
    ss_pin = 1'b0;
    if (glitch) sck_pin = 1'b1;
    spi_wait(HALF);
    if (glitch) begin
      sck_pin = 1'b0;
      spi_wait(HALF);
    end
  endtask

  task automatic ss_high();
    spi_wait(HALF);
    ss_pin = 1'b1;
    spi_wait(2 * HALF);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi_pin = tx[i];
      spi_wait(HALF);
      rx = {rx[6:0], miso};
      sck_pin = 1'b1;
      spi_wait(HALF);
      sck_pin = 1'b0;
    end
  endtask

  task automatic run_txn(input bit wr, input logic [6:0] addr, input int n, input bit glitch);
    logic [7:0] rx;
    logic [6:0] a;
    ev_t        e;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        e.wr = 1'b1; e.addr = addr + 7'(i); e.data = txd[i];
        sb.push_back(e);
      end
    end else begin
      for (int i = 0; i <= n; i++) begin
        e.wr = 1'b0; e.addr = addr + 7'(i); e.data = 8'h00;
        sb.push_back(e);
      end
    end
    check("idle_miso_en", {busy, miso_en}, 2'b00);
    ss_low(glitch);
    check("active_busy_miso_en", {busy, miso_en}, 2'b11);
    xfer({wr, addr}, 8, rx);
    check("cmd_miso", rx, 8'h00);
    for (int i = 0; i < n; i++) begin
      a = addr + 7'(i);
      if (wr) begin
        xfer(txd[i], 8, rx);
        check("wr_miso", rx, 8'h00);
      end else begin
        xfer(8'($urandom), 8, rx);
        check("rd_miso_byte", rx, rmem[a]);
      end
    end
    ss_high();
    check("end_busy_miso_en", {busy, miso_en}, 2'b00);
  endtask

  initial begin
    logic [7:0] rx;
    ev_t        e;

    for (int i = 0; i < 128; i++) rmem[i] = 8'($urandom);
    rmem[7'h10] = 8'hA5;
    rmem[7'h11] = 8'h5A;

    spi_wait(5);
    check("reset_outputs", {miso, miso_en, reg_addr, reg_wdata, reg_wr, reg_rd, busy}, 20'h0);
    nRst = 1'b1;
    spi_wait(10);
    check("post_reset_outputs", {miso, miso_en, reg_addr, reg_wdata, reg_wr, reg_rd, busy}, 20'h0);

    // Single write 0x85 / 0x3C
    txd[0] = 8'h3C;
    run_txn(1'b1, 7'h05, 1, 1'b0);

    // Burst write with wrap; SS fall coincides with an SCK rise
    txd[0] = 8'h11; txd[1] = 8'h22; txd[2] = 8'h33;
    run_txn(1'b1, 7'h7E, 3, 1'b1);

    // Read 0x10 with two data bytes
    run_txn(1'b0, 7'h10, 2, 1'b0);

    // Abort mid-byte
    ss_low(1'b0);
    xfer(8'h82, 8, rx);
    xfer(8'hF0, 4, rx);
    spi_wait(HALF);
    ss_pin = 1'b1;
    check("abort_busy_before", busy, 1'b1);
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    check("abort_busy_fall", busy, 1'b0);
    spi_wait(2 * HALF);
    txd[0] = 8'hC7;
    run_txn(1'b1, 7'h03, 1, 1'b0);

    // Reset in the middle of a burst write, released with SS low
    e.wr = 1'b1; e.addr = 7'h40; e.data = 8'hAB;
    sb.push_back(e);
    ss_low(1'b0);
    xfer(8'hC0, 8, rx);
    xfer(8'hAB, 8, rx);
    xfer(8'hCD, 4, rx);
    nRst = 1'b0;
    spi_wait(3);
    check("midreset_outputs", {miso, miso_en, reg_addr, reg_wdata, reg_wr, reg_rd, busy}, 20'h0);
    nRst = 1'b1;
    spi_wait(HALF);
    xfer(8'h81, 8, rx);
    xfer(8'h77, 8, rx);
    check("held_ss_no_start", {busy, miso_en}, 2'b00);
    ss_high();
    txd[0] = 8'h9E;
    run_txn(1'b1, 7'h03, 1, 1'b0);

    // en dropped during a read
    e.wr = 1'b0; e.addr = 7'h20; e.data = 8'h00;
    sb.push_back(e);
    e.addr = 7'h21;
    sb.push_back(e);
    ss_low(1'b0);
    xfer(8'h20, 8, rx);
    xfer(8'($urandom), 8, rx);
    check("en_rd_miso_byte", rx, rmem[7'h20]);
    xfer(8'($urandom), 3, rx);
    en = 1'b0;
    spi_wait(2);
    check("en_off_busy_miso_en", {busy, miso_en}, 2'b00);
    xfer(8'($urandom), 5, rx);
    xfer(8'($urandom), 8, rx);
    en = 1'b1;
    xfer(8'($urandom), 8, rx);
    check("en_on_no_restart", {busy, miso_en}, 2'b00);
    ss_high();

    // Randomized transactions
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
      run_txn(1'($urandom_range(0, 1)), 7'($urandom), int'($urandom_range(1, 3)), 1'b0);
    end

    spi_wait(20);
    check("scoreboard_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
SPI mode-0 slave that turns the external SPI pins into a simple register read/write bus for the breakout core. It is used for register access to game configuration and state.
- Sits directly upstream of the game logic.
- Consumes sck/ss/mosi.
- Drives miso/miso_en back to the top-level bidirectional pins.
- Issues single-cycle register strobes in the clk domain.

Parameters:
ADDR_W, 7, register address width. The command byte carries a 1-bit R/W flag plus ADDR_W address bits, so ADDR_W must be 7.
SYNC_STAGES, 2, number of synchronizer flops on each SPI input pin (minimum 2).

Ports:
clk  in  1  system clock; only clock in the block.
nRst  in  1  reset; synchronous, active-low.
en  in  1  design enable. When low, the block is held idle and ignores SPI activity.
sck_pin  in  1  raw SPI clock. Asynchronous; SCK high and low phases must each be ≥ 4 clk periods.
ss_pin  in  1  raw SPI select, active-low, asynchronous.
mosi_pin  in  1  raw SPI data in.
miso  out  1  SPI data out.
miso_en  out  1  output enable for miso.
reg_addr  out  ADDR_W  current register address.
reg_wdata  out  8  write data; valid while reg_wr=1.
reg_wr  out  1  one-cycle write strobe.
reg_rd  out  1  one-cycle read strobe.
reg_rdata  in  8  read data; must be valid the cycle after reg_rd.
busy  out  1  high while a transaction is active (synchronized SS low).

Behaviour:
- **Reset (nRst=0 at a clk edge):** the following are all 0:
  - outputs miso, miso_en, reg_addr, reg_wdata, reg_wr, reg_rd, busy;
  - state = IDLE, bit counter = 0;
  - synchronizer flops preset to sck=0, ss=1, mosi=0.
- **Input synchronization:**
  - Each pin passes through SYNC_STAGES flops plus one history flop.
  - Edges are detected in the clk domain: rise = cur & ~prev, fall = ~cur & prev.
  - All SPI-derived timing below is counted from the synchronized edge.
- **Framing:** mode 0 (CPOL=0, CPHA=0), MSB first.
  - MOSI is sampled on the SCK rise.
  - MISO changes on the SCK fall.
  - Byte 0 is the command: bit7 = 1 for write, 0 for read; bits6:0 = start address.
  - Following bytes are data, with the address auto-incrementing.
- **States:**
  - IDLE -> CMD on the synchronized SS fall while en=1.
  - CMD -> WR_DATA or RD_DATA after the 8th SCK rise.
  - WR_DATA / RD_DATA loop per byte.
  - Any state -> IDLE on synchronized SS high or en=0.
- **Command byte:**
  - On the 8th rise, reg_addr <= cmd[6:0].
  - For a read, reg_rd pulses on the cycle after the 8th rise.
  - The cycle after that, reg_rdata is captured into the tx shift register.
  - The tx register's MSB is driven on miso at the next SCK fall.
- **Write data:**
  - On the 8th rise of each data byte, reg_wdata <= the received byte and reg_wr=1 for exactly one cycle.
  - reg_addr is stable during the strobe and increments by 1 on the cycle after it.
- **Read data:**
  - Bits shift out on each fall.
  - On the 8th rise of each data byte: reg_addr increments, reg_rd pulses the next cycle, and reg_rdata is captured the cycle after that.
  - Any MOSI data received during a read is ignored.
- **Address wrap:** 7'h7F + 1 = 7'h00 (modulo 2^ADDR_W).
- **miso / miso_en:**
  - miso_en = busy.
  - miso = 0 during CMD and WR_DATA, and whenever idle.
- **SS abort mid-byte:**
  - The partial byte is discarded, with no reg_wr/reg_rd strobe for it.
  - The bit counter is cleared and the state returns to IDLE the cycle SS-high is detected.
  - Strobes already issued are not revoked.
- **SS fall and SCK edge in the same cycle:** the SCK edge is ignored; the transaction starts with the bit counter at 0.
- **en=0:** behaves like an SS abort. The block stays in IDLE and miso_en=0 until en=1 and a fresh SS fall is seen.
- **Strobe exclusivity:** reg_wr and reg_rd are never high in the same cycle.
- **Reset mid-transaction:** the block returns to its reset values. A new SS fall is required, so a select already held low when reset releases does not start a transaction.

Decomposition:
- Shared package breakout_pkg holds:
  - SPI_CMD_WR_BIT = 7 and SPI_ADDR_W = 7;
  - state enum spi_state_t {IDLE, CMD, WR_DATA, RD_DATA}.
- One sub-module, spi_pin_sync:
  - parameterized synchronizer + history flop for a single pin;
  - outputs level, rise, fall;
  - instantiated three times.

Test Plan:
- Write 0x85 then 0x3C -> one reg_wr with reg_addr=0x05, reg_wdata=0x3C; miso=0 throughout; miso_en high only while SS low.
- Burst write cmd 0xFE, data 0x11,0x22,0x33 -> reg_wr at addr 0x7E=0x11, 0x7F=0x22, then 0x00=0x33 (wrap); exactly 3 strobes.
- Read cmd 0x10 with bench reg_rdata = 0xA5 at addr 0x10 and 0x5A at 0x11, two data bytes clocked -> MISO shifts 0xA5 then 0x5A; reg_rd pulses at addr 0x10, 0x11 and 0x12.
- Write cmd 0x82, 4 data bits, then SS high -> no reg_wr; busy falls within SYNC_STAGES+1 clk; next full write to 0x03 works normally.
- nRst low during a burst write, then released with SS still low -> all outputs 0; no strobes until SS is raised and lowered again.
- en=0 during a read -> miso_en=0 and no reg_rd; SCK/MOSI toggling causes no strobes.
